// File: rtl/qam16_pkg.sv
// -----------------------------------------------------------------------------
// qam16_pkg
// Shared definitions for the QAM16 receive-side deframer.
//   state_t           : deframer state (HUNT for sync, PAYLOAD while packing)
//   SYM_W             : width of one demodulated symbol nibble
//   SYNC_BITS         : width of the frame sync word
//   DEFAULT_SYNC_WORD : default frame sync pattern, first nibble in [15:12]
// -----------------------------------------------------------------------------
package qam16_pkg;

  localparam int SYM_W     = 4;
  localparam int SYNC_BITS = 16;

  localparam logic [SYNC_BITS-1:0] DEFAULT_SYNC_WORD = 16'hA5C3;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

endpackage : qam16_pkg

// File: rtl/qam16_sync_detect.sv
// -----------------------------------------------------------------------------
// qam16_sync_detect
// Nibble shift register plus sync-word comparator.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_enable     : shift and compare only while hunting
//   i_clear      : zero the shift register
//   i_sym_valid  : i_sym_data is valid this cycle
//   i_sym_data   : demodulated nibble
//   o_match      : combinational pulse, the current nibble completes SYNC_WORD
// -----------------------------------------------------------------------------
module qam16_sync_detect
  import qam16_pkg::*;
#(
  parameter logic [SYNC_BITS-1:0] SYNC_WORD = DEFAULT_SYNC_WORD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic             i_sym_valid,
  input  logic [SYM_W-1:0] i_sym_data,
  output logic             o_match
);

  logic [SYNC_BITS-1:0] r_sr;
  logic [SYNC_BITS-1:0] w_sr_next;

  // Candidate window includes the nibble arriving now, so the match is
  // reported in the same cycle as the final sync nibble.
  assign w_sr_next = {r_sr[SYNC_BITS-SYM_W-1:0], i_sym_data};
  assign o_match   = i_enable && i_sym_valid && (w_sr_next == SYNC_WORD);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr <= '0;
    end else if (i_clear || o_match) begin
      r_sr <= '0;
    end else if (i_enable && i_sym_valid) begin
      // Not cleared on mismatch, so overlapping patterns are still found.
      r_sr <= w_sr_next;
    end
  end

endmodule : qam16_sync_detect

// File: rtl/qam16_rx_deframer.sv
// -----------------------------------------------------------------------------
// qam16_rx_deframer
// Hunts for a 16-bit sync word in the demodulated nibble stream, then packs
// PAYLOAD_BYTES bytes (first nibble in [7:4]) onto a valid/ready interface.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   sym_valid    : one-cycle strobe, sym_data valid
//   sym_data     : demodulated nibble
//   byte_data    : packed payload byte, stable while stalled
//   byte_valid   : byte_data valid, held until accepted
//   byte_ready   : consumer accepts when byte_valid && byte_ready
//   locked       : high while in PAYLOAD
//   frame_start  : one-cycle pulse after sync detection
//   frame_done   : one-cycle pulse with the last payload byte
//   overflow     : sticky, a completed byte was dropped under backpressure
// -----------------------------------------------------------------------------
module qam16_rx_deframer
  import qam16_pkg::*;
#(
  parameter logic [SYNC_BITS-1:0] SYNC_WORD     = DEFAULT_SYNC_WORD,
  parameter int                   PAYLOAD_BYTES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym_data,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             locked,
  output logic             frame_start,
  output logic             frame_done,
  output logic             overflow
);

  localparam int             CNT_W    = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_BYTES - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [SYM_W-1:0]   r_hi;
  logic               r_phase;
  logic [CNT_W-1:0]   r_count;
  logic [7:0]         r_byte_data;
  logic               r_byte_valid;
  logic               r_frame_start;
  logic               r_frame_done;
  logic               r_overflow;

  logic               w_match;
  logic               w_byte_done;
  logic               w_last;
  logic               w_can_load;

  qam16_sync_detect #(
    .SYNC_WORD (SYNC_WORD)
  ) u_sync_detect (
    .clk         (clk),
    .reset       (reset),
    .i_enable    (r_state == HUNT),
    .i_clear     (r_state == PAYLOAD),
    .i_sym_valid (sym_valid),
    .i_sym_data  (sym_data),
    .o_match     (w_match)
  );

  // A byte completes on the second nibble of each pair while in PAYLOAD.
  assign w_byte_done = (r_state == PAYLOAD) && sym_valid && r_phase;
  assign w_last      = w_byte_done && (r_count == LAST_IDX);
  // The output slot is free if empty or being drained on this edge.
  assign w_can_load  = !r_byte_valid || byte_ready;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: a default on the first line of the block keeps every path assigned,
  // so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      HUNT:    if (w_match) w_state_next = PAYLOAD;
      PAYLOAD: if (w_last)  w_state_next = HUNT;
      default: w_state_next = HUNT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packing, frame counter and status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi          <= '0;
      r_phase       <= 1'b0;
      r_count       <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_start <= w_match;
      r_frame_done  <= w_last;

      if (w_match) begin
        r_phase <= 1'b0;
        r_count <= '0;
      end else if ((r_state == PAYLOAD) && sym_valid) begin
        r_phase <= ~r_phase;
        if (!r_phase) begin
          r_hi <= sym_data;
        end else begin
          // Dropped bytes count too, keeping the frame boundary aligned.
          r_count <= w_last ? '0 : r_count + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output handshake and overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_byte_done && w_can_load) begin
        r_byte_data  <= {r_hi, sym_data};
        r_byte_valid <= 1'b1;
      end else if (r_byte_valid && byte_ready) begin
        r_byte_valid <= 1'b0;
      end

      if (w_byte_done && !w_can_load) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign byte_data   = r_byte_data;
  assign byte_valid  = r_byte_valid;
  assign locked      = (r_state == PAYLOAD);
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign overflow    = r_overflow;

endmodule : qam16_rx_deframer

// File: tb/tb_qam16_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_qam16_rx_deframer
// Self-checking bench: directed frames plus randomized traffic, compared each
// cycle against a queue-based reference model of the deframer.
// -----------------------------------------------------------------------------
module tb_qam16_rx_deframer;

  localparam logic [15:0] SYNC = 16'hA5C3;
  localparam int          PB   = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       sym_valid;
  logic [3:0] sym_data;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       locked;
  logic       frame_start;
  logic       frame_done;
  logic       overflow;

  always #5 clk = ~clk;

  qam16_rx_deframer #(
    .SYNC_WORD     (SYNC),
    .PAYLOAD_BYTES (PB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sym_valid   (sym_valid),
    .sym_data    (sym_data),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .locked      (locked),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: nibbles collected in a queue, interpreted per frame rule.
  bit         m_hunt  = 1'b1;
  logic [3:0] m_q[$];
  int         m_count = 0;
  logic [7:0] m_data  = '0;
  logic       m_valid = 1'b0;
  logic       m_start = 1'b0;
  logic       m_done  = 1'b0;
  logic       m_ovf   = 1'b0;

  logic [7:0] got[$];
  int         dut_starts = 0;
  int         dut_dones  = 0;

  task automatic check(input string tag, input logic [7:0] got_v,
                       input logic [7:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  task automatic model_step(input logic v, input logic [3:0] d,
                            input logic rdy, input logic rst);
    logic       produced;
    logic [7:0] b;
    produced = 1'b0;
    b        = '0;
    if (rst) begin
      m_hunt = 1'b1; m_q.delete(); m_count = 0; m_data = '0;
      m_valid = 1'b0; m_start = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
      return;
    end
    m_start = 1'b0;
    m_done  = 1'b0;
    if (v) begin
      m_q.push_back(d);
      if (m_hunt) begin
        if (m_q.size() > 4) void'(m_q.pop_front());
        if (m_q.size() == 4 && {m_q[0], m_q[1], m_q[2], m_q[3]} == SYNC) begin
          m_hunt = 1'b0; m_q.delete(); m_count = 0; m_start = 1'b1;
        end
      end else if (m_q.size() == 2) begin
        b = {m_q[0], m_q[1]};
        m_q.delete();
        produced = 1'b1;
        m_count++;
        if (m_count == PB) begin
          m_done = 1'b1; m_hunt = 1'b1; m_count = 0;
        end
      end
    end
    if (produced) begin
      if (!m_valid || rdy) begin
        m_data  = b;
        m_valid = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: drive at the falling edge, model at the rising edge, compare at
  // the next falling edge.
  task automatic cycle(input logic v, input logic [3:0] d,
                       input logic rdy, input logic rst);
    sym_valid  = v;
    sym_data   = d;
    byte_ready = rdy;
    reset      = rst;
    if (!rst && byte_valid === 1'b1 && rdy) got.push_back(byte_data);
    @(posedge clk);
    model_step(v, d, rdy, rst);
    @(negedge clk);
    check("byte_valid",  8'(byte_valid),  8'(m_valid));
    check("byte_data",   byte_data,       m_data);
    check("locked",      8'(locked),      8'(!m_hunt));
    check("frame_start", 8'(frame_start), 8'(m_start));
    check("frame_done",  8'(frame_done),  8'(m_done));
    check("overflow",    8'(overflow),    8'(m_ovf));
    if (frame_start === 1'b1) dut_starts++;
    if (frame_done === 1'b1)  dut_dones++;
  endtask

  task automatic send(input logic [3:0] d, input int gap, input logic rdy);
    for (int g = 0; g < gap; g++) cycle(1'b0, 4'h0, rdy, 1'b0);
    cycle(1'b1, d, rdy, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    got.delete();
    dut_starts = 0;
    dut_dones  = 0;
  endtask

  task automatic send_sync(input int gap, input logic rdy);
    logic [15:0] s;
    s = SYNC;
    for (int k = 0; k < 4; k++) send(s[15-4*k -: 4], gap, rdy);
  endtask

  // Expected bytes of a 0..F payload: 01,23,45,...,EF.
  task automatic check_frame_bytes(input string tag);
    logic [7:0] e;
    check({tag, "_count"}, 8'(got.size()), 8'(PB));
    for (int i = 0; i < PB && i < got.size(); i++) begin
      e = {4'((2 * i) % 16), 4'((2 * i + 1) % 16)};
      check(tag, got[i], e);
    end
  endtask

  initial begin
    logic [3:0] pend[$];
    logic [3:0] d;
    logic [15:0] s;

    sym_valid = 1'b0; sym_data = '0; byte_ready = 1'b0; reset = 1'b1;

    // Reset state
    do_reset();
    check("rst_valid", 8'(byte_valid), 8'h00);
    check("rst_data",  byte_data,      8'h00);
    check("rst_lock",  8'(locked),     8'h00);

    // Sync then payload
    send_sync(0, 1'b1);
    check("s1_start", 8'(frame_start), 8'h01);
    for (int k = 0; k < 16; k++) send(4'(k), 0, 1'b1);
    check("s1_done", 8'(frame_done), 8'h01);
    for (int k = 0; k < 3; k++) cycle(1'b0, 4'h0, 1'b1, 1'b0);
    check_frame_bytes("s1_byte");
    check("s1_unlock", 8'(locked), 8'h00);

    // Overlap and false start
    do_reset();
    send(4'hA, 0, 1'b1); send(4'h5, 0, 1'b1);
    send_sync(0, 1'b1);
    check("s2_starts", 8'(dut_starts), 8'h01);
    check("s2_nobyte", 8'(got.size()), 8'h00);
    for (int k = 0; k < 16; k++) send(4'(k), 0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    check_frame_bytes("s2_byte");

    // Backpressure: ready low for first three bytes, nibbles every 2nd cycle
    do_reset();
    send_sync(1, 1'b0);
    for (int k = 0; k < 16; k++) send(4'(k), 1, k >= 6);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    check("s3_ovf",   8'(overflow),   8'h01);
    check("s3_dones", 8'(dut_dones),  8'h01);
    check("s3_first", got.size() > 0 ? got[0] : 8'hxx, 8'h01);

    // Accept coincides with a new byte completing
    do_reset();
    send_sync(0, 1'b0);
    for (int k = 0; k < 16; k++) send(4'(k), 0, k[0] && k > 1);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    check("s4_ovf", 8'(overflow), 8'h00);

    // Reset mid-frame, then relock
    do_reset();
    send_sync(0, 1'b1);
    for (int k = 0; k < 6; k++) send(4'(k), 0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1, 1'b1);
    check("s5_valid", 8'(byte_valid), 8'h00);
    check("s5_lock",  8'(locked),     8'h00);
    got.delete(); dut_dones = 0;
    send_sync(0, 1'b1);
    for (int k = 0; k < 16; k++) send(4'(k), 0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    check_frame_bytes("s5_byte");
    check("s5_dones", 8'(dut_dones), 8'h01);

    // Gapped input
    do_reset();
    send_sync(5, 1'b1);
    for (int k = 0; k < 16; k++) send(4'(k), 5, 1'b1);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    check_frame_bytes("s6_byte");

    // Randomized traffic with injected sync words
    do_reset();
    s = SYNC;
    for (int c = 0; c < 4000; c++) begin
      if (pend.size() == 0) begin
        if ($urandom_range(0, 5) == 0) begin
          for (int k = 0; k < 4; k++) pend.push_back(s[15-4*k -: 4]);
        end else begin
          pend.push_back(4'($urandom_range(0, 15)));
        end
      end
      if ($urandom_range(0, 599) == 0) begin
        cycle(1'b0, 4'h0, 1'b0, 1'b1);
      end else if ($urandom_range(0, 2) != 0) begin
        d = pend.pop_front();
        cycle(1'b1, d, $urandom_range(0, 9) < 7, 1'b0);
      end else begin
        cycle(1'b0, 4'($urandom_range(0, 15)), $urandom_range(0, 9) < 7, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_qam16_rx_deframer
